alu_exec_seq: RTL
=================

# alu_exec_seq

Sequential execute-stage ALU that consumes the 3-bit `ALU_Ctrl` class code and `Sub` flag produced by the ALU control decoder, along with `Funct3`/`Funct7_5` and two operands. It produces a registered result and a branch-taken flag. Shifts run iteratively, one bit per cycle, so the block uses a valid/ready handshake on both sides. It sits between the register-read/operand-mux stage and the memory/writeback stage of the RV32I core.

## Interface
- `XLEN`, 32, operand and result width.
- `ALU_DECODER_IN`, 3, width of `ALU_Ctrl`.
- `CLK`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `in_valid`  in  1  operands and controls are valid.
- `in_ready`  out  1  block can accept an operation.
- `ALU_Ctrl`  in  `ALU_DECODER_IN`  operation class: 000 add/sub, 001 set-less-than, 010 logic, 011 shift, 100 branch compare, others no-op.
- `Sub`  in  1  subtract select for class 000.
- `Funct3`  in  3  sub-operation select.
- `Funct7_5`  in  1  for shift right: 0 selects SRL, 1 selects SRA.
- `SrcA`, `SrcB`  in  `XLEN`  operands.
- `out_valid`  out  1  result registers hold a completed operation.
- `out_ready`  in  1  consumer takes the result.
- `ALU_Result`  out  `XLEN`  result.
- `Branch_Taken`  out  1  branch condition outcome; 0 for every non-branch class.
- `busy`  out  1  high in `SHIFT` state.

## Operation
- States: `IDLE`, `SHIFT`, `DONE`.
- `in_ready` = (state == `IDLE`).
- Accept occurs when `in_valid` and `in_ready` are both high at a rising edge.
- All inputs are sampled only at accept. Later changes are ignored.
- Class 000: `Sub` ? `SrcA`−`SrcB` : `SrcA`+`SrcB`, modulo 2^XLEN, carry discarded.
- Class 001:
  - `Funct3` 010 → signed less-than.
  - `Funct3` 011 → unsigned less-than.
  - Result is zero-extended, 0 or 1.
  - Other `Funct3` values → 0.
- Class 010: `Funct3` 111 AND, 110 OR, 100 XOR; other values → 0.
- Class 011:
  - `shamt` = `SrcB[4:0]`.
  - `Funct3` 001 SLL; 101 with `Funct7_5`=0 SRL; 101 with `Funct7_5`=1 SRA (sign-fill).
  - Other `Funct3` values → result 0, treated as `shamt`=0.
- Class 100:
  - `Funct3` 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU.
  - Result 0 and `Branch_Taken` = condition.
  - `Funct3` 010/011 → taken 0.
- Classes 101/110/111: accepted as a no-op; result 0, taken 0.
- Transitions:
  - `IDLE` → `DONE` on accept of any non-shift op, or a shift with `shamt`=0. Result and taken flag are registered at the accept edge; a shift with `shamt`=0 gives result `SrcA`.
  - `IDLE` → `SHIFT` on accept of a shift with `shamt`≥1. The working register is loaded with `SrcA`, the counter with `shamt`, and the shift kind is latched.
  - `SHIFT`: each edge shifts the working register by 1 bit and decrements the counter. On the edge where the counter goes 1→0, the state moves to `DONE` and `ALU_Result` takes the final value.
  - `DONE` → `IDLE` when `out_valid` and `out_ready` are both high at an edge.
- `out_valid` = (state == `DONE`). `ALU_Result` and `Branch_Taken` hold stable while `out_valid` is high and `out_ready` is low.
- `ALU_Result` and `Branch_Taken` are registered outputs; they change only at accept (non-shift) or at the final shift edge.

## Timing
- Reset (`rst` high at an edge):
  - State → `IDLE`.
  - `out_valid`, `busy`, `Branch_Taken` → 0; `ALU_Result` → 0; counter → 0.
  - `in_ready` = 1 in the first cycle after reset.
- Reset mid-`SHIFT` or mid-`DONE` aborts the operation and no result is delivered.
- Latency, counted from the accept edge to `out_valid` high:
  - 1 cycle for non-shift ops and `shamt`=0.
  - `shamt` cycles for `shamt`≥1; maximum 31.
- Throughput: at most one op per 2 cycles, because there is no accept in `DONE`. The earliest next accept is the edge after the `DONE`→`IDLE` handshake edge.
- `in_valid` high during `SHIFT`/`DONE` is ignored and holds no side state.

## Test plan
- Add/sub: class 000, `Sub`=1, A=5, B=7 → `ALU_Result`=0xFFFFFFFE, `out_valid` one cycle after accept. `Sub`=0, A=0xFFFFFFFF, B=1 → 0.
- Compare: class 001, A=0xFFFFFFFF, B=1. `Funct3`=010 → 1; `Funct3`=011 → 0.
- Shift:
  - SRA: A=0x80000000, B=4, `Funct3`=101, `Funct7_5`=1 → 0xF8000000 after exactly 4 cycles, with `busy` high for those 4 cycles.
  - SLL: A=1, B=31 → 0x80000000 after 31 cycles.
  - B=0 → A after 1 cycle.
- Branch: class 100, A=0x80000000, B=1. `Funct3`=101 (BGE) → taken 0; `Funct3`=111 (BGEU) → taken 1; `ALU_Result`=0 in both cases.
- Backpressure: complete an op with `out_ready` low for 5 cycles.
  - `out_valid` and the result stay stable and `in_ready` stays 0 throughout.
  - Raise `out_ready` → `in_ready`=1 the next cycle.
  - A new `in_valid` during the stall is not accepted.
- Reset mid-shift: start SRL with `shamt`=20 and assert `rst` at cycle 6 → all outputs return to reset values, `out_valid` never rises, `in_ready`=1 after reset.

Source files
------------

// File: rtl/alu_exec_seq.sv
// Sequential execute-stage ALU: single-cycle arithmetic/logic/branch compare,
// iterative one-bit-per-cycle shifter, valid/ready handshake on both sides.
module alu_exec_seq #(
   parameter int XLEN           = 32,
   parameter int ALU_DECODER_IN = 3
) (
   input  logic                      CLK,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [ALU_DECODER_IN-1:0] ALU_Ctrl,
   input  logic                      Sub,
   input  logic [2:0]                Funct3,
   input  logic                      Funct7_5,
   input  logic [XLEN-1:0]           SrcA,
   input  logic [XLEN-1:0]           SrcB,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [XLEN-1:0]           ALU_Result,
   output logic                      Branch_Taken,
   output logic                      busy
);

   // state | meaning
   // IDLE  | ready to accept an operation
   // SHIFT | iterative shift in progress, one bit per cycle
   // DONE  | result registered, waiting for out_ready
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   typedef enum logic [1:0] {SK_NONE, SK_SLL, SK_SRL, SK_SRA} shift_kind_t;

   localparam int SHW = $clog2(XLEN);
   localparam logic [SHW-1:0] CNT_ONE = SHW'(1);

   localparam logic [ALU_DECODER_IN-1:0] CLS_ADD   = ALU_DECODER_IN'(0);
   localparam logic [ALU_DECODER_IN-1:0] CLS_SLT   = ALU_DECODER_IN'(1);
   localparam logic [ALU_DECODER_IN-1:0] CLS_LOGIC = ALU_DECODER_IN'(2);
   localparam logic [ALU_DECODER_IN-1:0] CLS_SHIFT = ALU_DECODER_IN'(3);
   localparam logic [ALU_DECODER_IN-1:0] CLS_BR    = ALU_DECODER_IN'(4);

   state_t          state, state_next;
   shift_kind_t     kind_in, kind_q;
   logic [XLEN-1:0] work_q, work_step;
   logic [SHW-1:0]  cnt_q;
   logic [SHW-1:0]  shamt;
   logic            accept;
   logic            shift_start;
   logic [XLEN-1:0] op_result;
   logic            op_taken;
   logic            lt_s, lt_u, eq;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state == SHIFT);
   assign accept    = in_valid && in_ready;
   assign shamt     = SrcB[SHW-1:0];

   assign lt_s = $signed(SrcA) < $signed(SrcB);
   assign lt_u = SrcA < SrcB;
   assign eq   = SrcA == SrcB;

   always_comb begin
      kind_in = SK_NONE;
      if (Funct3 == 3'b001)
         kind_in = SK_SLL;
      else if (Funct3 == 3'b101)
         kind_in = Funct7_5 ? SK_SRA : SK_SRL;
   end

   assign shift_start = accept && (ALU_Ctrl == CLS_SHIFT) &&
                        (kind_in != SK_NONE) && (shamt != '0);

   // Non-shift result; for the shift class this only covers shamt=0 / bad Funct3.
   always_comb begin
      op_result = '0;
      op_taken  = 1'b0;
      case (ALU_Ctrl)
         CLS_ADD:   op_result = Sub ? (SrcA - SrcB) : (SrcA + SrcB);
         CLS_SLT: begin
            if (Funct3 == 3'b010)
               op_result = {{(XLEN-1){1'b0}}, lt_s};
            else if (Funct3 == 3'b011)
               op_result = {{(XLEN-1){1'b0}}, lt_u};
         end
         CLS_LOGIC: begin
            case (Funct3)
               3'b111:  op_result = SrcA & SrcB;
               3'b110:  op_result = SrcA | SrcB;
               3'b100:  op_result = SrcA ^ SrcB;
               default: op_result = '0;
            endcase
         end
         CLS_SHIFT: op_result = (kind_in != SK_NONE) ? SrcA : '0;
         CLS_BR: begin
            case (Funct3)
               3'b000:  op_taken = eq;
               3'b001:  op_taken = !eq;
               3'b100:  op_taken = lt_s;
               3'b101:  op_taken = !lt_s;
               3'b110:  op_taken = lt_u;
               3'b111:  op_taken = !lt_u;
               default: op_taken = 1'b0;
            endcase
         end
         default: begin
            op_result = '0;
            op_taken  = 1'b0;
         end
      endcase
   end

   always_comb begin
      case (kind_q)
         SK_SLL:  work_step = {work_q[XLEN-2:0], 1'b0};
         SK_SRL:  work_step = {1'b0, work_q[XLEN-1:1]};
         SK_SRA:  work_step = {work_q[XLEN-1], work_q[XLEN-1:1]};
         default: work_step = work_q;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (accept)
               state_next = shift_start ? SHIFT : DONE;
         end
         SHIFT: begin
            if (cnt_q == CNT_ONE)
               state_next = DONE;
         end
         DONE: begin
            if (out_ready)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (rst) begin
         work_q       <= '0;
         cnt_q        <= '0;
         kind_q       <= SK_NONE;
         ALU_Result   <= '0;
         Branch_Taken <= 1'b0;
      end else if (accept) begin
         if (shift_start) begin
            work_q <= SrcA;
            cnt_q  <= shamt;
            kind_q <= kind_in;
         end else begin
            ALU_Result   <= op_result;
            Branch_Taken <= op_taken;
         end
      end else if (state == SHIFT) begin
         work_q <= work_step;
         cnt_q  <= cnt_q - CNT_ONE;
         if (cnt_q == CNT_ONE) begin
            ALU_Result   <= work_step;
            Branch_Taken <= 1'b0;
         end
      end
   end

endmodule
